// File: rtl/cnn_tile_ctrl_pkg.sv
// cnn_tile_ctrl_pkg
//   Shared definitions for the CNN layer sequencer: default field widths
//   and the controller state encoding.
//   No ports; imported by cnn_tile_ctrl and cnn_loop_cnt.
package cnn_tile_ctrl_pkg;

    localparam int DEF_W_SIZE       = 9;
    localparam int DEF_W_CHANNEL    = 10;
    localparam int DEF_W_FRAME_SIZE = 18;
    localparam int DEF_W_TILE       = 8;
    localparam int DEF_TILE_CO      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLOAD = 3'd1,
        ST_CSYNC = 3'd2,
        ST_DATA  = 3'd3,
        ST_PSYNC = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/cnn_tile_ctrl_loop_cnt.sv
// cnn_loop_cnt
//   Wrap counter used for each loop level of the layer walk. Advances by
//   'step' when enabled and returns to 0 once value + step reaches 'limit'.
//   Ports:
//     clk, rstn      clock, asynchronous active-low reset
//     en             advance this cycle
//     clear          synchronous return to 0 (has priority over en)
//     step [W-1:0]   increment
//     limit [W:0]    loop bound; one bit wider so value + step never wraps
//     value [W-1:0]  current count
//     is_last        value + step >= limit
//     wrap           en && is_last (counter returns to 0 this cycle)
module cnn_loop_cnt
    import cnn_tile_ctrl_pkg::*;
#(
    parameter int W = DEF_W_SIZE
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] step,
    input  logic [W:0]   limit,
    output logic [W-1:0] value,
    output logic         is_last,
    output logic         wrap
);

    logic [W-1:0] r_value;
    logic [W:0]   w_sum;

    assign w_sum   = {1'b0, r_value} + {1'b0, step};
    assign is_last = (w_sum >= limit);
    assign wrap    = en & is_last;
    assign value   = r_value;

    // Count register: clear wins, otherwise step forward or wrap to zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= '0;
        end else if (en) begin
            r_value <= is_last ? '0 : w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/cnn_tile_ctrl.sv
// cnn_tile_ctrl
//   Layer sequencer: walks output-channel tiles x rows x cols x input
//   channels (stride 1 or 2), with a filter-load handshake per tile and a
//   psum-sync handshake per row.
//   Ports:
//     clk, rstn                       clock, asynchronous active-low reset
//     q_width/q_height/q_channel/
//     q_channel_out/q_stride2         layer configuration, latched at start
//     q_start                         start request (rising edge accepted)
//     fb_load_done, pb_sync_done      handshake completion pulses
//     o_fb_load_req                   filter load request level
//     o_ctrl_*_run                    phase strobes
//     o_layer_done, o_busy            completion pulse, busy level
//     o_row/o_col/o_chn/o_tile        current position
//     o_is_*                          boundary flags, valid while data runs
module cnn_tile_ctrl
    import cnn_tile_ctrl_pkg::*;
#(
    parameter int W_SIZE    = DEF_W_SIZE,
    parameter int W_CHANNEL = DEF_W_CHANNEL,
    parameter int TILE_CO   = DEF_TILE_CO,
    parameter int W_TILE    = DEF_W_TILE
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [W_SIZE-1:0]    q_width,
    input  logic [W_SIZE-1:0]    q_height,
    input  logic [W_CHANNEL-1:0] q_channel,
    input  logic [W_CHANNEL-1:0] q_channel_out,
    input  logic                 q_stride2,
    input  logic                 q_start,
    input  logic                 fb_load_done,
    input  logic                 pb_sync_done,
    output logic                 o_fb_load_req,
    output logic                 o_ctrl_csync_run,
    output logic                 o_ctrl_data_run,
    output logic                 o_ctrl_psync_run,
    output logic                 o_layer_done,
    output logic                 o_busy,
    output logic [W_SIZE-1:0]    o_row,
    output logic [W_SIZE-1:0]    o_col,
    output logic [W_CHANNEL-1:0] o_chn,
    output logic [W_TILE-1:0]    o_tile,
    output logic                 o_is_first_row,
    output logic                 o_is_last_row,
    output logic                 o_is_first_col,
    output logic                 o_is_last_col,
    output logic                 o_is_first_chn,
    output logic                 o_is_last_chn,
    output logic                 o_is_last_tile
);

    localparam int LOG2_TILE = $clog2(TILE_CO);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_start_s;
    logic                 r_start_prev;
    logic [W_SIZE-1:0]    r_width;
    logic [W_SIZE-1:0]    r_height;
    logic [W_CHANNEL-1:0] r_channel;
    logic [W_CHANNEL-1:0] r_channel_out;
    logic                 r_stride2;
    logic                 r_fb_load_req;
    logic                 r_csync_run;
    logic                 r_data_run;
    logic                 r_psync_run;
    logic                 r_layer_done;
    logic                 r_busy;

    logic                 w_start_edge;
    logic                 w_accept;
    logic                 w_zero_cfg;
    logic [W_SIZE-1:0]    w_step;
    logic [W_CHANNEL:0]   w_co_round;
    logic [W_CHANNEL:0]   w_tiles_full;
    logic [W_TILE:0]      w_tile_limit;
    logic [W_CHANNEL-1:0] w_chn;
    logic [W_SIZE-1:0]    w_col;
    logic [W_SIZE-1:0]    w_row;
    logic [W_TILE-1:0]    w_tile;
    logic                 w_chn_last;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_tile_last;
    logic                 w_chn_en;
    logic                 w_col_en;
    logic                 w_row_en;
    logic                 w_tile_en;

    // q_start is synchronised once, then compared with its previous sample,
    // so only a genuine low-to-high transition is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start_s    <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_start_s    <= q_start;
            r_start_prev <= r_start_s;
        end
    end

    assign w_start_edge = r_start_s & ~r_start_prev;
    assign w_accept     = (r_state == ST_IDLE) & w_start_edge;
    assign w_zero_cfg   = (q_width == '0) | (q_height == '0) |
                          (q_channel == '0) | (q_channel_out == '0);

    // Configuration is captured only at acceptance; later input changes
    // cannot disturb a running layer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_width       <= '0;
            r_height      <= '0;
            r_channel     <= '0;
            r_channel_out <= '0;
            r_stride2     <= 1'b0;
        end else if (w_accept) begin
            r_width       <= q_width;
            r_height      <= q_height;
            r_channel     <= q_channel;
            r_channel_out <= q_channel_out;
            r_stride2     <= q_stride2;
        end
    end

    assign w_step       = {{(W_SIZE-2){1'b0}}, r_stride2, ~r_stride2};
    assign w_co_round   = {1'b0, r_channel_out} + (W_CHANNEL+1)'(TILE_CO - 1);
    assign w_tiles_full = w_co_round >> LOG2_TILE;
    assign w_tile_limit = (W_TILE+1)'(w_tiles_full);

    // chn is innermost; col steps on a channel wrap; row and tile advance
    // only when the psum sync for a row completes.
    assign w_chn_en  = (r_state == ST_DATA);
    assign w_col_en  = w_chn_en & w_chn_last;
    assign w_row_en  = (r_state == ST_PSYNC) & pb_sync_done;
    assign w_tile_en = w_row_en & w_row_last;

    cnn_loop_cnt #(.W(W_CHANNEL)) u_chn_cnt (
        .clk(clk), .rstn(rstn), .en(w_chn_en), .clear(w_accept),
        .step(W_CHANNEL'(1)), .limit({1'b0, r_channel}),
        .value(w_chn), .is_last(w_chn_last), .wrap()
    );

    cnn_loop_cnt #(.W(W_SIZE)) u_col_cnt (
        .clk(clk), .rstn(rstn), .en(w_col_en), .clear(w_accept),
        .step(w_step), .limit({1'b0, r_width}),
        .value(w_col), .is_last(w_col_last), .wrap()
    );

    cnn_loop_cnt #(.W(W_SIZE)) u_row_cnt (
        .clk(clk), .rstn(rstn), .en(w_row_en), .clear(w_accept),
        .step(w_step), .limit({1'b0, r_height}),
        .value(w_row), .is_last(w_row_last), .wrap()
    );

    cnn_loop_cnt #(.W(W_TILE)) u_tile_cnt (
        .clk(clk), .rstn(rstn), .en(w_tile_en), .clear(w_accept),
        .step(W_TILE'(1)), .limit(w_tile_limit),
        .value(w_tile), .is_last(w_tile_last), .wrap()
    );

    // Next-state logic. Handshake pulses are only looked at in the state
    // that waits for them, so stray pulses elsewhere have no effect.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_next = w_zero_cfg ? ST_DONE : ST_FLOAD;
                end
            end
            ST_FLOAD: begin
                if (fb_load_done) begin
                    w_state_next = ST_CSYNC;
                end
            end
            ST_CSYNC: w_state_next = ST_DATA;
            ST_DATA: begin
                if (w_chn_last && w_col_last) begin
                    w_state_next = ST_PSYNC;
                end
            end
            ST_PSYNC: begin
                if (pb_sync_done) begin
                    if (!w_row_last) begin
                        w_state_next = ST_CSYNC;
                    end else if (!w_tile_last) begin
                        w_state_next = ST_FLOAD;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State and strobes are registered from the next state so that every
    // strobe lines up exactly with the state it belongs to.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_fb_load_req <= 1'b0;
            r_csync_run   <= 1'b0;
            r_data_run    <= 1'b0;
            r_psync_run   <= 1'b0;
            r_layer_done  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fb_load_req <= (w_state_next == ST_FLOAD);
            r_csync_run   <= (w_state_next == ST_CSYNC);
            r_data_run    <= (w_state_next == ST_DATA);
            r_psync_run   <= (w_state_next == ST_PSYNC);
            r_layer_done  <= (w_state_next == ST_DONE);
            r_busy        <= (w_state_next == ST_FLOAD) | (w_state_next == ST_CSYNC) |
                             (w_state_next == ST_DATA)  | (w_state_next == ST_PSYNC);
        end
    end

    assign o_fb_load_req    = r_fb_load_req;
    assign o_ctrl_csync_run = r_csync_run;
    assign o_ctrl_data_run  = r_data_run;
    assign o_ctrl_psync_run = r_psync_run;
    assign o_layer_done     = r_layer_done;
    assign o_busy           = r_busy;
    assign o_row            = w_row;
    assign o_col            = w_col;
    assign o_chn            = w_chn;
    assign o_tile           = w_tile;

    // Flags are only meaningful while data runs; outside that they stay low.
    assign o_is_first_row = r_data_run & (w_row == '0);
    assign o_is_last_row  = r_data_run & w_row_last;
    assign o_is_first_col = r_data_run & (w_col == '0);
    assign o_is_last_col  = r_data_run & w_col_last;
    assign o_is_first_chn = r_data_run & (w_chn == '0);
    assign o_is_last_chn  = r_data_run & w_chn_last;
    assign o_is_last_tile = r_data_run & w_tile_last;

endmodule
